seg_scan_driver: RTL

Time-multiplexed 7-segment scan driver sitting directly downstream of the adder/display segment decoders. It accepts a packed word of per-digit segment patterns (a..g, as produced by the display decoder), double-buffers it, and scans the digits one at a time with anode dead-time to suppress ghosting. Pattern updates commit only on frame boundaries, so a frame is never torn.

---
 rtl/seg_scan_driver.sv | 107 ++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver with double-buffered patterns and anode dead-time.
// Optional half-brightness input `dim` is compiled in when SEG_SCAN_DIM_EN is defined.
module seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int DEAD        = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [7*NUM_DIGITS-1:0] seg_in,
`ifdef SEG_SCAN_DIM_EN
  input  logic                    dim,
`endif
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CW   = $clog2(REFRESH_DIV);
  localparam int DW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int HALF = DEAD + (REFRESH_DIV - DEAD) / 2;

  typedef enum logic {BLANK, SCAN} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [DW-1:0]           dig;
  logic [7*NUM_DIGITS-1:0] pending;
  logic [7*NUM_DIGITS-1:0] active;
  logic                    pend_v;
  logic                    wrap_q;

  logic                    last_cnt;
  logic                    boundary;
  logic                    lit;
  logic [6:0]              cur_seg;
  logic [NUM_DIGITS-1:0]   onehot;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    last_cnt = (cnt == CW'(REFRESH_DIV - 1));
    boundary = last_cnt && (dig == DW'(NUM_DIGITS - 1));
    lit      = (int'(cnt) >= DEAD);
`ifdef SEG_SCAN_DIM_EN
    if (dim && (int'(cnt) >= HALF)) lit = 1'b0;
`endif
    cur_seg     = active[7*dig +: 7];
    onehot      = '0;
    onehot[dig] = 1'b1;
  end

  // Outputs are registered from the current counter, so the visible slot lags cnt by one cycle.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BLANK;
      cnt        <= '0;
      dig        <= '0;
      pending    <= '0;
      active     <= '0;
      pend_v     <= 1'b0;
      wrap_q     <= 1'b0;
      seg        <= '0;
      an         <= '0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        BLANK: begin
          seg        <= '0;
          an         <= '0;
          frame_done <= 1'b0;
          wrap_q     <= 1'b0;
          if (load) begin
            active <= seg_in;
            state  <= SCAN;
            cnt    <= '0;
            dig    <= '0;
          end
        end
        SCAN: begin
          seg        <= cur_seg;
          an         <= lit ? onehot : '0;
          wrap_q     <= boundary;
          frame_done <= wrap_q;
          if (last_cnt) begin
            cnt <= '0;
            dig <= boundary ? '0 : dig + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
          // On a boundary the old pending word commits; a coincident load waits a frame.
          if (boundary) begin
            if (pend_v) active <= pending;
            pend_v <= load;
            if (load) pending <= seg_in;
          end else if (load) begin
            pending <= seg_in;
            pend_v  <= 1'b1;
          end
        end
        default: state <= BLANK;
      endcase
    end
  end

endmodule
